// File: rtl/compare_result_tally.sv
// compare_result_tally: tallies comparator result codes over fixed-length frames.
// Each accepted 3-bit code bumps one of gt/eq/lt/err. When the last code of a
// frame is accepted, the counts and a majority flag are latched into the
// output registers and held until the consumer acknowledges the report.
module compare_result_tally #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  input  logic [2:0]       iCmp,
  output logic             oReady,
  input  logic             iClear,
  input  logic             iAck,
  output logic             oDone,
  output logic [CNT_W-1:0] oGtCnt,
  output logic [CNT_W-1:0] oEqCnt,
  output logic [CNT_W-1:0] oLtCnt,
  output logic [CNT_W-1:0] oErrCnt,
  output logic [2:0]       oMajority
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic {COLLECT, REPORT} state_t;

  state_t           state;
  logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt, sample_cnt;
  logic [CNT_W-1:0] gt_nxt, eq_nxt, lt_nxt, err_nxt;
  logic             accept;

  // One-hot largest of gt/eq/lt; ties resolve eq > gt > lt, all-zero gives 000.
  function automatic logic [2:0] majority(input logic [CNT_W-1:0] gt,
                                          input logic [CNT_W-1:0] eq,
                                          input logic [CNT_W-1:0] lt);
    logic [2:0] m;
    m = 3'b000;
    if (eq != '0 && eq >= gt && eq >= lt) m = 3'b010;
    else if (gt != '0 && gt >= lt)        m = 3'b100;
    else if (lt != '0)                    m = 3'b001;
    return m;
  endfunction

  assign accept = iValid && oReady;

  // Category counts including the code currently on iCmp.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gt_nxt  = gt_cnt;
    eq_nxt  = eq_cnt;
    lt_nxt  = lt_cnt;
    err_nxt = err_cnt;
    case (iCmp)
      3'b100:  gt_nxt  = gt_cnt + ONE;
      3'b010:  eq_nxt  = eq_cnt + ONE;
      3'b001:  lt_nxt  = lt_cnt + ONE;
      default: err_nxt = err_cnt + ONE;
    endcase
  end

  // Frame FSM: collect codes, latch the report, wait for acknowledge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (!iRst_n) begin
      state      <= COLLECT;
      oReady     <= 1'b1;
      oDone      <= 1'b0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
      oGtCnt     <= '0;
      oEqCnt     <= '0;
      oLtCnt     <= '0;
      oErrCnt    <= '0;
      oMajority  <= 3'b000;
    end else if (iClear) begin
      // Abort drops the partial frame but keeps the last report visible.
      state      <= COLLECT;
      oReady     <= 1'b1;
      oDone      <= 1'b0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (sample_cnt == LAST_IDX) begin
              oGtCnt     <= gt_nxt;
              oEqCnt     <= eq_nxt;
              oLtCnt     <= lt_nxt;
              oErrCnt    <= err_nxt;
              oMajority  <= majority(gt_nxt, eq_nxt, lt_nxt);
              gt_cnt     <= '0;
              eq_cnt     <= '0;
              lt_cnt     <= '0;
              err_cnt    <= '0;
              sample_cnt <= '0;
              oDone      <= 1'b1;
              oReady     <= 1'b0;
              state      <= REPORT;
            end else begin
              gt_cnt     <= gt_nxt;
              eq_cnt     <= eq_nxt;
              lt_cnt     <= lt_nxt;
              err_cnt    <= err_nxt;
              sample_cnt <= sample_cnt + ONE;
            end
          end
        end
        REPORT: begin
          if (iAck) begin
            oDone  <= 1'b0;
            oReady <= 1'b1;
            state  <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_result_tally.sv
// Bench for compare_result_tally with FRAME_LEN = 4: a table of frames with
// their expected reports, a report queue, plus hold, abort and async-reset cases.
module tb_compare_result_tally;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 8;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iValid = 1'b0;
  logic [2:0]       iCmp = 3'b000;
  logic             oReady;
  logic             iClear = 1'b0;
  logic             iAck = 1'b0;
  logic             oDone;
  logic [CNT_W-1:0] oGtCnt, oEqCnt, oLtCnt, oErrCnt;
  logic [2:0]       oMajority;

  compare_result_tally #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .iCmp(iCmp),
    .oReady(oReady), .iClear(iClear), .iAck(iAck), .oDone(oDone),
    .oGtCnt(oGtCnt), .oEqCnt(oEqCnt), .oLtCnt(oLtCnt), .oErrCnt(oErrCnt),
    .oMajority(oMajority)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int         gt, eq, lt, err;
    logic [2:0] maj;
  } report_t;

  typedef struct {
    logic [2:0] codes [FRAME_LEN];
    report_t    exp;
  } frame_t;

  report_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_counts(input string name, input report_t r);
    check({name, "_gt"},  int'(oGtCnt),    r.gt);
    check({name, "_eq"},  int'(oEqCnt),    r.eq);
    check({name, "_lt"},  int'(oLtCnt),    r.lt);
    check({name, "_err"}, int'(oErrCnt),   r.err);
    check({name, "_maj"}, int'(oMajority), int'(r.maj));
  endtask

  // Present one code for one cycle; inputs change 1 time unit after the edge.
  task automatic send(input logic [2:0] code);
    iValid = 1'b1;
    iCmp   = code;
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k == FRAME_LEN - 1) sb_q.push_back(f.exp);
      send(f.codes[k]);
    end
  endtask

  // Wait (bounded) for a report and compare it with the oldest expectation.
  task automatic wait_report(input string name);
    report_t r;
    int n = 0;
    while (!oDone && n < 20) begin
      @(posedge iClk); #1;
      n++;
    end
    check({name, "_done"}, int'(oDone), 1);
    check({name, "_ready"}, int'(oReady), 0);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      r = sb_q.pop_front();
      check_counts(name, r);
    end
  endtask

  task automatic ack();
    iAck = 1'b1;
    @(posedge iClk); #1;
    iAck = 1'b0;
  endtask

  frame_t  tbl [6];
  report_t held;
  frame_t  f;

  initial begin
    tbl[0].codes = '{3'b001, 3'b100, 3'b001, 3'b010}; tbl[0].exp = '{1, 1, 2, 0, 3'b001};
    tbl[1].codes = '{3'b000, 3'b111, 3'b010, 3'b100}; tbl[1].exp = '{1, 1, 0, 2, 3'b010};
    tbl[2].codes = '{3'b010, 3'b010, 3'b001, 3'b001}; tbl[2].exp = '{0, 2, 2, 0, 3'b010};
    tbl[3].codes = '{3'b100, 3'b001, 3'b100, 3'b001}; tbl[3].exp = '{2, 0, 2, 0, 3'b100};
    tbl[4].codes = '{3'b000, 3'b011, 3'b101, 3'b110}; tbl[4].exp = '{0, 0, 0, 4, 3'b000};
    tbl[5].codes = '{3'b001, 3'b001, 3'b001, 3'b100}; tbl[5].exp = '{1, 0, 3, 0, 3'b001};

    // Reset state
    #12 iRst_n = 1'b1;
    @(posedge iClk); #1;
    check("rst_ready", int'(oReady), 1);
    check("rst_done", int'(oDone), 0);
    check_counts("rst", '{0, 0, 0, 0, 3'b000});

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i]);
      // Report must already be valid one cycle after the last accepted code.
      check($sformatf("f%0d_latency", i), int'(oDone), 1);
      wait_report($sformatf("f%0d", i));
      if (i == 0) begin
        // Report is held while inputs keep arriving without acknowledge.
        for (int k = 0; k < 5; k++) send(3'b100);
        check("hold_done", int'(oDone), 1);
        check_counts("hold", tbl[0].exp);
      end
      ack();
      check($sformatf("f%0d_ack_done", i), int'(oDone), 0);
      check($sformatf("f%0d_ack_ready", i), int'(oReady), 1);
    end

    // Abort: two codes, then a clear cycle with a valid code that must be dropped.
    held = tbl[5].exp;
    send(3'b010);
    send(3'b010);
    iClear = 1'b1;
    send(3'b001);
    iClear = 1'b0;
    check("clr_done", int'(oDone), 0);
    check("clr_ready", int'(oReady), 1);
    check_counts("clr_held", held);
    f.codes = '{3'b100, 3'b100, 3'b100, 3'b100};
    f.exp   = '{4, 0, 0, 0, 3'b100};
    for (int k = 0; k < 3; k++) send(3'b100);
    check("clr_no_early_done", int'(oDone), 0);
    sb_q.push_back(f.exp);
    send(3'b100);
    wait_report("clr_frame");
    ack();

    // Async reset mid-frame, then a fresh frame must count from zero.
    send(3'b100);
    send(3'b001);
    #3 iRst_n = 1'b0;
    #1 check("rst_mid_ready", int'(oReady), 1);
    #2 iRst_n = 1'b1;
    @(posedge iClk); #1;
    f.codes = '{3'b100, 3'b010, 3'b001, 3'b001};
    f.exp   = '{1, 1, 2, 0, 3'b001};
    send_frame(f);
    wait_report("post_mid_rst");

    // Async reset while in REPORT, between clock edges.
    #3 iRst_n = 1'b0;
    #1;
    check("arst_done", int'(oDone), 0);
    check("arst_ready", int'(oReady), 1);
    check_counts("arst", '{0, 0, 0, 0, 3'b000});
    #2 iRst_n = 1'b1;
    @(posedge iClk); #1;
    f.codes = '{3'b010, 3'b010, 3'b010, 3'b010};
    f.exp   = '{0, 4, 0, 0, 3'b010};
    send_frame(f);
    wait_report("post_arst");
    ack();

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
